// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: request, tagged response and fpu drive signals; slave = arbiter view, master = environment view
interface fpu_arbiter_if #(
  parameter int LOG_BIT = 5,
  parameter int N_REQ = 4,
  parameter int N_BIT = 1 << LOG_BIT,
  parameter int ID_BIT = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*N_BIT-1:0] req_a;
  logic [N_REQ*N_BIT-1:0] req_b;
  logic [N_REQ*2-1:0] req_op;
  logic resp_valid;
  logic resp_ready;
  logic [N_BIT-1:0] resp_data;
  logic [ID_BIT-1:0] resp_id;
  logic resp_err;
  logic [N_BIT-1:0] fpu_a;
  logic [N_BIT-1:0] fpu_b;
  logic [1:0] fpu_op;
  logic fpu_start;
  logic [N_BIT-1:0] fpu_out;
  logic fpu_ready;
  logic busy;
  modport slave (
    input req_valid, req_a, req_b, req_op, resp_ready, fpu_out, fpu_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err, fpu_a, fpu_b, fpu_op, fpu_start, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, fpu_out, fpu_ready,
    input req_ready, resp_valid, resp_data, resp_id, resp_err, fpu_a, fpu_b, fpu_op, fpu_start, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin share of one fpu among N_REQ requesters; ports clk, rst, io (slave: requests in, tagged response out, fpu operands/start out, fpu result/ready in, busy out)
module fpu_arbiter #(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8,
  parameter int N_BIT = 1 << LOG_BIT,
  parameter int N_REQ = 4,
  parameter int ID_BIT = $clog2(N_REQ),
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  fpu_arbiter_if.slave io
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, MWAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [ID_BIT-1:0] rr_q, rr_d, id_q, id_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_BIT-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0] op_q, op_d;
  logic err_q, err_d, found;
  if (EXP_BIT > 0) begin : g_exp
  end
  always_comb begin
    found = |io.req_valid;
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (io.req_valid[k]) win = ID_BIT'(k);
    for (int k = N_REQ - 1; k >= 0; k--) if (io.req_valid[k] && ID_BIT'(k) >= rr_q) win = ID_BIT'(k);
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (found) begin
        a_d = io.req_a[win*N_BIT +: N_BIT];
        b_d = io.req_b[win*N_BIT +: N_BIT];
        op_d = io.req_op[win*2 +: 2];
        id_d = win;
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = '0;
        state_d = op_q[1] ? MWAIT : RESP;
        data_d = op_q[1] ? data_q : io.fpu_out;
        err_d = op_q[1] ? err_q : 1'b0;
      end
      MWAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0 && io.fpu_ready) begin
          data_d = io.fpu_out;
          err_d = 1'b0;
          state_d = RESP;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          data_d = '0;
          err_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (io.resp_ready) begin
        rr_d = id_q == ID_BIT'(N_REQ - 1) ? '0 : id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign io.req_ready = (state_q == IDLE && found && !rst) ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign io.resp_valid = state_q == RESP;
  assign io.resp_data = data_q;
  assign io.resp_id = id_q;
  assign io.resp_err = err_q;
  assign io.fpu_a = a_q;
  assign io.fpu_b = b_q;
  assign io.fpu_op = op_q;
  assign io.fpu_start = state_q == EXEC && op_q[1];
  assign io.busy = state_q != IDLE;
endmodule
